// File: rtl/uart_rx_frame_if.sv
// Purpose: word-side bundle of uart_rx_frame (received word, error qualifiers, overrun, consumer ready).
// Latency: none, wires only.
// Backpressure: rx_ready from the consumer; a transfer happens on rx_valid && rx_ready at a clock edge.
interface uart_rx_frame_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 frame_err;
    logic                 parity_err;
    logic                 overrun;

    // Receiver side: produces the word and its qualifiers.
    modport master (
        output rx_data,
        output rx_valid,
        output frame_err,
        output parity_err,
        output overrun,
        input  rx_ready
    );

    // Consumer side: observes the word and accepts it.
    modport slave (
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  parity_err,
        input  overrun,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_frame.sv
// Purpose: parametrised UART receiver (5-9 data bits, none/odd/even parity, 1-2 stop bits), 2-flop input sync.
// Latency: rx_valid rises 1 clk after the final stop-bit centre sample (+1 clk with UART_RX_MAJORITY_EN).
// Backpressure: one-word holding register; a frame completing while a word is still held is dropped with an overrun pulse.
// Optional build macro UART_RX_MAJORITY_EN: 2-of-3 majority vote around each bit centre.
module uart_rx_frame #(
    parameter int CLKS_PER_BIT = 1250,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic uart_rx,
    uart_rx_frame_if.master rx,
    output logic busy
);

    localparam int CW  = $clog2(CLKS_PER_BIT);
    localparam int MID = CLKS_PER_BIT / 2;

    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

`ifdef UART_RX_MAJORITY_EN
    // Votes are gathered at MID-2 and MID-1; the decision is taken at MID.
    localparam logic [CW-1:0] CNT_VOTE_A = CW'(MID - 2);
    localparam logic [CW-1:0] CNT_VOTE_B = CW'(MID - 1);
    localparam logic [CW-1:0] CNT_SAMPLE = CW'(MID);
`else
    localparam logic [CW-1:0] CNT_SAMPLE = CW'(MID - 1);
`endif

    localparam logic [3:0] LAST_DATA_IDX = 4'(DATA_BITS - 1);
    localparam logic       LAST_STOP_IDX = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    state_t               state;
    logic                 rx_m;
    logic                 rx_s;
    logic [CW-1:0]        cnt;
    logic [3:0]           bit_idx;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 perr_acc;
    logic                 ferr_acc;
    logic                 deliver;

    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 ferr_q;
    logic                 perr_q;
    logic                 overrun_q;

    logic                 sample_now;
    logic                 sample_bit;

    // Two-flop synchroniser for the asynchronous serial line; resets to the idle (high) level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= uart_rx;
            rx_s <= rx_m;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic vote_a;
    logic vote_b;

    // Capture the two early votes of each bit; the third vote is rx_s at the decision cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vote_a <= 1'b1;
            vote_b <= 1'b1;
        end else begin
            if (cnt == CNT_VOTE_A) begin
                vote_a <= rx_s;
            end
            if (cnt == CNT_VOTE_B) begin
                vote_b <= rx_s;
            end
        end
    end

    assign sample_now = (cnt == CNT_SAMPLE);
    assign sample_bit = (vote_a & vote_b) | (vote_a & rx_s) | (vote_b & rx_s);
`else
    assign sample_now = (cnt == CNT_SAMPLE);
    assign sample_bit = rx_s;
`endif

    // Frame FSM. The bit counter starts at 0 on the start edge and then wraps modulo
    // CLKS_PER_BIT for the whole frame, so the same counter value marks the centre of
    // every bit: the start sample and each later sample are exactly one bit period apart.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            shreg    <= '0;
            perr_acc <= 1'b0;
            ferr_acc <= 1'b0;
            deliver  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            deliver <= 1'b0;

            if (state != S_IDLE && state != S_BREAK) begin
                cnt <= (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
            end

            case (state)
                S_IDLE: begin
                    if (!rx_s) begin
                        state <= S_START;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end

                S_START: begin
                    if (sample_now) begin
                        if (sample_bit) begin
                            // Line back high at the start-bit centre: a glitch, not a frame.
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state    <= S_DATA;
                            bit_idx  <= '0;
                            perr_acc <= 1'b0;
                            ferr_acc <= 1'b0;
                        end
                    end
                end

                S_DATA: begin
                    if (sample_now) begin
                        // LSB arrives first, so shift in from the top.
                        shreg <= {sample_bit, shreg[DATA_BITS-1:1]};
                        if (bit_idx == LAST_DATA_IDX) begin
                            state    <= (PARITY != 0) ? S_PARITY : S_STOP;
                            stop_idx <= 1'b0;
                        end else begin
                            bit_idx <= bit_idx + 4'd1;
                        end
                    end
                end

                S_PARITY: begin
                    if (sample_now) begin
                        // Odd parity wants an odd total of ones, even wants an even total.
                        perr_acc <= (((^shreg) ^ sample_bit) != (PARITY == 1));
                        state    <= S_STOP;
                    end
                end

                S_STOP: begin
                    if (sample_now) begin
                        if (!sample_bit) begin
                            ferr_acc <= 1'b1;
                        end
                        if (stop_idx == LAST_STOP_IDX) begin
                            deliver <= 1'b1;
                            if (ferr_acc || !sample_bit) begin
                                // Wait for the line to recover so a held-low line yields one word only.
                                state <= S_BREAK;
                            end else begin
                                state <= S_IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            stop_idx <= 1'b1;
                        end
                    end
                end

                S_BREAK: begin
                    if (rx_s) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Output holding register: load on delivery when empty or draining this cycle, otherwise flag overrun.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            perr_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            if (deliver) begin
                if (!valid_q || rx.rx_ready) begin
                    data_q  <= shreg;
                    ferr_q  <= ferr_acc;
                    perr_q  <= perr_acc;
                    valid_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (valid_q && rx.rx_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign rx.rx_data    = data_q;
    assign rx.rx_valid   = valid_q;
    assign rx.frame_err  = ferr_q;
    assign rx.parity_err = perr_q;
    assign rx.overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Purpose: directed bench for uart_rx_frame: 8N1 unit (A) and 8E1 unit (B) on a short bit period.
// Latency: expected words are hand-computed per frame; first-word latency is checked against the start edge.
// Backpressure: rx_ready is held high except in the overrun and reset scenarios.
module tb_uart_rx_frame;

    localparam int C   = 16;
    localparam int MID = C / 2;
`ifdef UART_RX_MAJORITY_EN
    localparam int MAJ_DLY = 1;
    localparam logic [7:0] GLITCH_EXP = 8'h00;
`else
    localparam int MAJ_DLY = 0;
    localparam logic [7:0] GLITCH_EXP = 8'h04;
`endif

    logic clk = 1'b0;
    logic rst;
    logic ua;
    logic ub;
    logic busy_a;
    logic busy_b;

    uart_rx_frame_if #(.DATA_BITS(8)) ifa ();
    uart_rx_frame_if #(.DATA_BITS(8)) ifb ();

    uart_rx_frame #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst(rst), .uart_rx(ua), .rx(ifa), .busy(busy_a)
    );

    uart_rx_frame #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut_b (
        .clk(clk), .rst(rst), .uart_rx(ub), .rx(ifb), .busy(busy_b)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int t0_a     = 0;
    int rise_a   = -1;
    int vhi_a    = 0;
    int ovr_a    = 0;
    logic prev_valid_a = 1'b0;
    logic [9:0] qa[$];
    logic [9:0] qb[$];

    always @(posedge clk) cyc = cyc + 1;

    // Word monitor: sampled 1 time unit after the falling edge; a transfer happens at the next rising edge.
    always @(negedge clk) begin
        #1;
        if (ifa.rx_valid && ifa.rx_ready) qa.push_back({ifa.frame_err, ifa.parity_err, ifa.rx_data});
        if (ifb.rx_valid && ifb.rx_ready) qb.push_back({ifb.frame_err, ifb.parity_err, ifb.rx_data});
        if (ifa.rx_valid) vhi_a = vhi_a + 1;
        if (ifa.overrun) ovr_a = ovr_a + 1;
        if (ifa.rx_valid && !prev_valid_a && rise_a < 0) rise_a = cyc;
        prev_valid_a = ifa.rx_valid;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [9:0] qget(input int which, input int i);
        if (which == 0) return (i < qa.size()) ? qa[i] : 10'h3FF;
        return (i < qb.size()) ? qb[i] : 10'h3FF;
    endfunction

    task automatic drive(input int ln, input logic v);
        if (ln == 0) ua = v;
        else ub = v;
    endtask

    task automatic idle(input int n);
        ua = 1'b1;
        ub = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // One frame: start, 8 data bits LSB first, optional parity bit, one stop bit.
    // gl_bit inverts a single cycle at the centre of that frame bit; rst_bit stops mid-way through that frame bit.
    task automatic send_frame(input int ln, input logic [7:0] d, input bit has_par, input logic pbit,
                              input logic stop_v, input int gl_bit, input int rst_bit);
        logic [10:0] bits;
        int n;
        logic v;
        bits = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = d[i];
        n = 9;
        if (has_par) begin
            bits[n] = pbit;
            n = n + 1;
        end
        bits[n] = stop_v;
        n = n + 1;
        for (int b = 0; b < n; b++) begin
            for (int k = 0; k < C; k++) begin
                @(negedge clk);
                if (b == rst_bit && k == MID) return;
                if (b == 0 && k == 0 && ln == 0) t0_a = cyc;
                v = bits[b];
                if (b == gl_bit && k == MID) v = ~v;
                drive(ln, v);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        ua = 1'b1;
        ub = 1'b1;
        ifa.rx_ready = 1'b1;
        ifb.rx_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_data",   ifa.rx_data,    0);
        check_eq("rst_valid",  ifa.rx_valid,   0);
        check_eq("rst_ferr",   ifa.frame_err,  0);
        check_eq("rst_perr",   ifa.parity_err, 0);
        check_eq("rst_ovr",    ifa.overrun,    0);
        check_eq("rst_busy",   busy_a,         0);
        @(negedge clk);
        rst = 1'b0;
        idle(2 * C);

        // 8N1 stream with rx_ready high.
        qa.delete();
        vhi_a = 0;
        rise_a = -1;
        send_frame(0, 8'h01, 0, 1'b0, 1'b1, -1, -1);
        idle(C);
        check_eq("latency", rise_a - t0_a, MID + 4 + 9 * C + MAJ_DLY);
        send_frame(0, 8'h02, 0, 1'b0, 1'b1, -1, -1);
        idle(C);
        send_frame(0, 8'h68, 0, 1'b0, 1'b1, -1, -1);
        idle(2 * C);
        check_eq("n8n1_cnt", qa.size(), 3);
        check_eq("w_01", qget(0, 0), {2'b00, 8'h01});
        check_eq("w_02", qget(0, 1), {2'b00, 8'h02});
        check_eq("w_68", qget(0, 2), {2'b00, 8'h68});
        check_eq("vld_cycles", vhi_a, 3);

        // False start: low for a quarter bit only.
        qa.delete();
        @(negedge clk);
        ua = 1'b0;
        repeat (4) @(negedge clk);
        ua = 1'b1;
        #1;
        check_eq("fs_busy_hi", busy_a, 1);
        repeat (MID + 4) @(negedge clk);
        #1;
        check_eq("fs_busy_lo", busy_a, 0);
        idle(2 * C);
        check_eq("fs_nowords", qa.size(), 0);

        // Even parity on unit B: 0x68 has three ones, so parity bit 1 is correct and 0 is an error.
        qb.delete();
        send_frame(1, 8'h68, 1, 1'b0, 1'b1, -1, -1);
        idle(C);
        send_frame(1, 8'h68, 1, 1'b1, 1'b1, -1, -1);
        idle(2 * C);
        check_eq("par_cnt",  qb.size(), 2);
        check_eq("par_bad",  qget(1, 0), {2'b01, 8'h68});
        check_eq("par_good", qget(1, 1), {2'b00, 8'h68});

        // Stop bit low, line held low for five more bit times.
        qa.delete();
        send_frame(0, 8'h55, 0, 1'b0, 1'b0, -1, -1);
        repeat (5 * C) @(negedge clk);
        #1;
        check_eq("brk_cnt",  qa.size(), 1);
        check_eq("brk_word", qget(0, 0), {2'b10, 8'h55});
        check_eq("brk_busy", busy_a, 1);
        idle(2 * C);
        #1;
        check_eq("brk_exit", busy_a, 0);
        check_eq("brk_cnt2", qa.size(), 1);
        send_frame(0, 8'h5A, 0, 1'b0, 1'b1, -1, -1);
        idle(2 * C);
        check_eq("brk_next", qget(0, 1), {2'b00, 8'h5A});

        // Overrun with the consumer stalled.
        qa.delete();
        ovr_a = 0;
        ifa.rx_ready = 1'b0;
        send_frame(0, 8'hA1, 0, 1'b0, 1'b1, -1, -1);
        idle(C);
        send_frame(0, 8'hB2, 0, 1'b0, 1'b1, -1, -1);
        idle(C);
        check_eq("ovr_valid", ifa.rx_valid, 1);
        check_eq("ovr_data",  ifa.rx_data,  8'hA1);
        check_eq("ovr_pulse", ovr_a, 1);
        ifa.rx_ready = 1'b1;
        @(negedge clk);
        #1;
        check_eq("ovr_drain", ifa.rx_valid, 0);
        check_eq("ovr_word",  qget(0, 0), {2'b00, 8'hA1});
        idle(C);

        // Reset in the middle of data bit 4 while a word is still held.
        ifa.rx_ready = 1'b0;
        send_frame(0, 8'h5A, 0, 1'b0, 1'b1, -1, -1);
        idle(C);
        check_eq("pre_rst_valid", ifa.rx_valid, 1);
        send_frame(0, 8'h3C, 0, 1'b0, 1'b1, -1, 5);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_valid", ifa.rx_valid, 0);
        check_eq("mid_rst_data",  ifa.rx_data,  0);
        check_eq("mid_rst_busy",  busy_a,       0);
        @(negedge clk);
        rst = 1'b0;
        ifa.rx_ready = 1'b1;
        idle(2 * C);
        qa.delete();
        send_frame(0, 8'hC3, 0, 1'b0, 1'b1, -1, -1);
        idle(2 * C);
        check_eq("post_rst_cnt",  qa.size(), 1);
        check_eq("post_rst_word", qget(0, 0), {2'b00, 8'hC3});

        // One-cycle high pulse at the centre of data bit 2 of 0x00.
        qa.delete();
        send_frame(0, 8'h00, 0, 1'b0, 1'b1, 3, -1);
        idle(2 * C);
        check_eq("glitch_word", qget(0, 0), {2'b00, GLITCH_EXP});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
